dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Streaming FIFO controller that sits directly upstream of dpram (32x1024 SRAM wrapper) and drives its wen/ren/waddr/raddr/d_in.
//  Converts a valid/ready write stream into SRAM writes and SRAM reads back into a valid/ready read stream.
//  Hides the 1-cycle SRAM read latency with a 2-entry output buffer, sustaining 1 word/cycle in each direction.
// PARAMETERS
//  DATA_W   32    word width; must equal dpram d_in/d_out width
//  ADDR_W   10    SRAM address width; DEPTH = 2**ADDR_W = 1024 words
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  clear      in   1       synchronous flush, same effect as reset, takes priority over all traffic
//  s_valid    in   1       write stream valid
//  s_ready    out  1       write stream ready (SRAM not full)
//  s_data     in   DATA_W  write stream data
//  m_valid    out  1       read stream valid
//  m_ready    in   1       read stream ready
//  m_data     out  DATA_W  read stream data (head of output buffer)
//  level      out  ADDR_W+2  words accepted and not yet delivered (SRAM + in-flight + buffer), 0..DEPTH+2
//  mem_wen    out  1       to dpram.wen, active-high
//  mem_waddr  out  ADDR_W  to dpram.waddr
//  mem_din    out  DATA_W  to dpram.d_in
//  mem_ren    out  1       to dpram.ren, active-high
//  mem_raddr  out  ADDR_W  to dpram.raddr
//  mem_dout   in   DATA_W  from dpram.d_out, valid the cycle after mem_ren
// BEHAVIOUR
//  Reset/clear (rst_n=0 or clear=1 at edge): wptr=rptr=0, sram_cnt=0, inflight=0, buffer empty;
//   s_ready=1, m_valid=0, level=0, mem_wen=0, mem_ren=0; in-flight read data discarded.
//  Write: push = s_valid & s_ready. mem_wen=push, mem_waddr=wptr, mem_din=s_data (combinational pass-through).
//   s_ready = (sram_cnt != DEPTH); depends on registered state only, never on s_valid.
//  Read issue: mem_ren = (sram_cnt != 0) & (buf_cnt + inflight - pop < 2), pop = m_valid & m_ready; mem_raddr=rptr.
//   Only words committed to SRAM on an earlier edge are readable, so no same-cycle read/write collision on one address.
//  inflight <= mem_ren; cycle after mem_ren, mem_dout is written into output buffer tail.
//  Pointers: wptr += push, rptr += mem_ren, wrap DEPTH-1 -> 0 naturally (ADDR_W-bit).
//  sram_cnt <= sram_cnt + push - mem_ren (simultaneous push and ren: unchanged).
//  Output buffer: 2 entries, FIFO order; m_valid = buf_cnt!=0; m_data = head; simultaneous fill and pop allowed.
//  level <= level + push - pop.
//  Latency: s handshake at edge E0 on empty FIFO -> mem_ren in cycle after E0 -> captured at E2 -> m_valid=1 after E2.
//  Throughput: with s_valid=1 and m_ready=1 continuously, steady state 1 word/cycle each side, no bubbles.
//  Full: sram_cnt==DEPTH -> s_ready=0; a push is accepted in the same cycle a read frees a slot only from the next cycle.
//  Backpressure: m_ready=0 -> buffer fills to 2, then mem_ren=0; no data lost or duplicated.
//  Buffer never overflows: buf_cnt + inflight <= 2 invariant (assert in sim).
// STRUCTURE
//  Shared package/header: DATA_W=32, ADDR_W=10, DEPTH constant matching the mem32x1024 macro, used by dpram too.
//  One sub-module: fifo_out_buf (2-entry register FIFO: push/pop/data/count, sync active-low reset).
//  Top holds pointers, sram_cnt, inflight flag, level counter, and issue logic.
// TESTING
//  Reset then single word 0xDEADBEEF with m_ready=1 -> mem_wen one cycle at waddr 0; m_valid after 3 cycles, m_data=0xDEADBEEF, level back to 0.
//  Stream 2000 incrementing words, s_valid=m_ready=1 -> one word/cycle after fill latency, in-order, pointers wrap 1023->0 without loss.
//  Write 1024 words with m_ready=0 -> 2 drained into buffer, s_ready stays 1 until sram_cnt=1024; level=1026 max with extra 2 writes, then s_ready=0.
//  Random s_valid/m_ready toggling (50%), 10k words -> scoreboard exact order, buf_cnt+inflight<=2 always.
//  Assert clear mid-stream with a read in flight -> next cycle m_valid=0, level=0, s_ready=1; subsequent word 0x1 emerges first.
//  Drop rst_n for one edge with FIFO half full -> all outputs at reset values; asynchronous-looking glitch on rst_n between edges has no effect.

Source files
------------

// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dpram FIFO controller and the mem32x1024 SRAM wrapper.
// Holds the word/address geometry and the output-buffer occupancy helper.
package dpram_fifo_ctrl_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DEPTH  = 1024;

    // Occupancy the output buffer will have once pending reads land and the current pop retires.
    function automatic logic [2:0] buf_occupancy(
        input logic [1:0] buf_cnt,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_out_buf.sv
// Two-entry register FIFO that absorbs SRAM read data and presents it to the read stream.
module fifo_out_buf
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_r [2];
    logic              head_r;
    logic              tail_r;
    logic [1:0]        cnt_r;

    // Entry storage, head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
            head_r   <= 1'b0;
            tail_r   <= 1'b0;
            cnt_r    <= 2'b00;
        end else begin
            if (push) begin
                mem_r[tail_r] <= din;
                tail_r        <= ~tail_r;
            end
            if (pop) begin
                head_r <= ~head_r;
            end
            cnt_r <= cnt_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout  = mem_r[head_r];
    assign count = cnt_r;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Streaming FIFO controller in front of the dpram SRAM wrapper: valid/ready write stream to
// SRAM writes, SRAM reads back to a valid/ready read stream, read latency hidden by a 2-entry buffer.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W+1:0] level,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int              LVL_W    = ADDR_W + 2;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [ADDR_W:0]   sram_cnt_r;
    logic              inflight_r;
    logic [LVL_W-1:0]  level_r;
    logic [1:0]        buf_cnt_s;
    logic              push_s;
    logic              pop_s;
    logic              ren_s;

    assign s_ready = (sram_cnt_r != FULL_CNT);
    assign push_s  = s_valid & s_ready;
    assign m_valid = (buf_cnt_s != 2'b00);
    assign pop_s   = m_valid & m_ready;

    // A read is only issued when the buffer is guaranteed a free slot on arrival;
    // sram_cnt counts words committed on earlier edges, so a read never hits the word being written.
    assign ren_s = (sram_cnt_r != {(ADDR_W+1){1'b0}})
                 & (buf_occupancy(buf_cnt_s, inflight_r, pop_s) < 3'd2);

    assign mem_wen   = push_s;
    assign mem_waddr = wptr_r;
    assign mem_din   = s_data;
    assign mem_ren   = ren_s;
    assign mem_raddr = rptr_r;
    assign level     = level_r;

    // Pointers, SRAM occupancy, read-in-flight flag and end-to-end level.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wptr_r     <= {ADDR_W{1'b0}};
            rptr_r     <= {ADDR_W{1'b0}};
            sram_cnt_r <= {(ADDR_W+1){1'b0}};
            inflight_r <= 1'b0;
            level_r    <= {LVL_W{1'b0}};
        end else begin
            wptr_r     <= wptr_r + {{(ADDR_W-1){1'b0}}, push_s};
            rptr_r     <= rptr_r + {{(ADDR_W-1){1'b0}}, ren_s};
            sram_cnt_r <= sram_cnt_r + {{ADDR_W{1'b0}}, push_s} - {{ADDR_W{1'b0}}, ren_s};
            inflight_r <= ren_s;
            level_r    <= level_r + {{(LVL_W-1){1'b0}}, push_s} - {{(LVL_W-1){1'b0}}, pop_s};
        end
    end

    fifo_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (inflight_r),
        .din   (mem_dout),
        .pop   (pop_s),
        .dout  (m_data),
        .count (buf_cnt_s)
    );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural 32x1024 SRAM attached.
module tb_dpram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'h0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [11:0] level;
    logic        mem_wen;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_din;
    logic        mem_ren;
    logic [9:0]  mem_raddr;
    logic [31:0] mem_dout;

    logic [31:0] sram [0:1023];

    dpram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle registered read
    always @(posedge clk) begin
        if (mem_wen) sram[mem_waddr] <= mem_din;
        if (mem_ren) mem_dout <= sram[mem_raddr];
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          first_mark = -1;
    int          first_pop_cyc = 0;
    int          inv_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records accepted writes, checks every delivered word in order
    always @(negedge clk) begin
        cyc++;
        if (int'(dut.buf_cnt_s) + int'(dut.inflight_r) > 2) inv_err++;
        if (!rst_n || clear) begin
            exp_q.delete();
        end else begin
            if (m_valid && m_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (pop_cnt == first_mark) first_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got %h expected no word", m_data);
                end else begin
                    check("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pbase;
        int abase;
        int n;

        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_level",   64'(level),   64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_mem_ren", 64'(mem_ren), 64'd0);

        // Single word latency
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        #1;
        check("sw_wen",   64'(mem_wen),   64'd1);
        check("sw_waddr", 64'(mem_waddr), 64'd0);
        check("sw_din",   64'(mem_din),   64'hDEADBEEF);
        tick();
        s_valid = 1'b0;
        #1;
        check("sw_ren",    64'(mem_ren),   64'd1);
        check("sw_raddr",  64'(mem_raddr), 64'd0);
        check("sw_level1", 64'(level),     64'd1);
        check("sw_mv_e0",  64'(m_valid),   64'd0);
        tick();
        check("sw_mv_e1",  64'(m_valid),   64'd0);
        check("sw_ren_e1", 64'(mem_ren),   64'd0);
        tick();
        check("sw_mv_e2",  64'(m_valid),   64'd1);
        check("sw_data",   64'(m_data),    64'hDEADBEEF);
        tick();
        check("sw_mv_e3",  64'(m_valid),   64'd0);
        check("sw_level0", 64'(level),     64'd0);

        // Continuous stream, wraps the pointers
        pbase = pop_cnt;
        abase = acc_cnt;
        first_mark = pbase + 1;
        m_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            s_valid = 1'b1;
            s_data  = i;
            tick();
        end
        drain("stream_drain", 100);
        check("stream_acc",  64'(acc_cnt - abase), 64'd2000);
        check("stream_pops", 64'(pop_cnt - pbase), 64'd2000);
        check("stream_span", 64'(last_pop_cyc - first_pop_cyc), 64'd1999);
        check("stream_level", 64'(level), 64'd0);

        // Fill to full with the read side stalled
        m_ready = 1'b0;
        abase = acc_cnt;
        for (int i = 0; i < 1026; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h1000_0000 + i;
            tick();
        end
        check("full_acc",     64'(acc_cnt - abase), 64'd1026);
        check("full_level",   64'(level),   64'd1026);
        check("full_s_ready", 64'(s_ready), 64'd0);
        check("full_mem_wen", 64'(mem_wen), 64'd0);
        check("full_mem_ren", 64'(mem_ren), 64'd0);
        repeat (3) tick();
        check("full_hold_acc",   64'(acc_cnt - abase), 64'd1026);
        check("full_hold_level", 64'(level), 64'd1026);
        drain("full_drain", 1200);

        // Random valid/ready toggling
        abase = acc_cnt;
        n = 0;
        while ((acc_cnt - abase) < 10000 && n < 60000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("rand_words", 64'((acc_cnt - abase) >= 10000), 64'd1);
        drain("rand_drain", 2000);
        check("rand_level", 64'(level), 64'd0);

        // Clear with a read in flight
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA0A0_0000;
        tick();
        s_data  = 32'hA0A0_0001;
        tick();
        s_valid = 1'b0;
        #1;
        check("clr_pre_inflight", 64'(dut.inflight_r), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("clr_m_valid", 64'(m_valid), 64'd0);
        check("clr_level",   64'(level),   64'd0);
        check("clr_s_ready", 64'(s_ready), 64'd1);
        check("clr_mem_ren", 64'(mem_ren), 64'd0);
        repeat (3) tick();
        check("clr_stays_empty", 64'(m_valid), 64'd0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h1;
        tick();
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 10) begin
            tick();
            n++;
        end
        check("clr_first_word", 64'(m_data), 64'h1);
        drain("clr_drain", 20);

        // Half full, then rst_n glitch between edges, then a real reset
        m_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h5000_0000 + i;
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        check("half_level", 64'(level), 64'd512);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("glitch_level",   64'(level),   64'd512);
        check("glitch_m_valid", 64'(m_valid), 64'd1);
        check("glitch_m_data",  64'(m_data),  64'h5000_0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_s_ready", 64'(s_ready), 64'd1);
        check("rst2_m_valid", 64'(m_valid), 64'd0);
        check("rst2_level",   64'(level),   64'd0);
        check("rst2_mem_wen", 64'(mem_wen), 64'd0);
        check("rst2_mem_ren", 64'(mem_ren), 64'd0);

        check("buf_invariant", 64'(inv_err), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
